uart_rx_param: RTL and testbench

Parametrised UART receiver: the next-generation serial input stage for the design. It recovers asynchronous 8N1/8E1/8O1-style frames with configurable oversampling and word width, using mid-bit sampling behind a two-flop synchroniser. It holds each received word in an output register with a valid/ack handshake, and flags framing, parity and overrun errors. It sits between the external serial pin and any byte-consuming logic, and runs entirely on the system clock with no separate baud clock.

---
 rtl/uart_rx_param.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with mid-bit sampling, valid/ack output register and error flags.
// Define UART_RX_PARITY_EN to expect one parity bit between the data bits and the stop bit.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] TOP  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    localparam logic   ODD        = PARITY_ODD != 0;
`else
    localparam state_t AFTER_DATA = STOP;
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD != 0;
`endif

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rxs, tick, ack, done;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign rxs  = sync_q[1];
    assign tick = cnt_q == LAST;
    assign ack  = rx_ack & rx_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], serial_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                shift_d = '0;
                state_d = rxs ? IDLE : START;
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == MID) begin
                    cnt_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    shift_d = shift_q | (DATA_BITS'(rxs) << idx_q);
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    state_d = idx_q == TOP ? AFTER_DATA : DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    perr_d  = rxs ^ (^shift_q) ^ ODD;
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = rxs ? IDLE : BREAK;
                end
            end
            BREAK:   state_d = rxs ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end

    // A completing frame overrides a same-cycle ack; the acked word is not an overrun.
    always_comb begin
        rx_data_d   = done ? shift_q : rx_data_q;
        rx_valid_d  = done | (rx_valid_q & ~ack);
        frame_err_d = done ? ~rxs : frame_err_q & ~ack;
        overrun_d   = ~ack & (overrun_q | (done & rx_valid_q));
`ifdef UART_RX_PARITY_EN
        parity_err_d = done ? perr_q : parity_err_q & ~ack;
`endif
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized frames against a frame-level model; a monitor pops expected words as the receiver presents them.
module tb_uart_rx_param;
    localparam int C = 8;
    localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int DW = 7;
    localparam int P  = 1;
`else
    localparam int DW = 8;
    localparam int P  = 0;
`endif
    localparam int ODD = 0;
    localparam int L   = 2 + H + (DW + 1 + P) * C;

    logic          clk = 1'b0, rst = 1'b1, serial_in = 1'b1, rx_ack = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid, frame_err, parity_err, overrun_err, busy;

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(DW), .PARITY_ODD(ODD)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .parity_err(parity_err), .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        bit            ferr, perr, ovr;
        longint        t;
    } exp_t;

    exp_t   sb[$];
    exp_t   m_e;
    int     checks = 0, errors = 0;
    longint cyc = 0;
    bit     held = 0, ovr_m = 0;
    logic [DW-1:0] p_data = '0;
    logic   p_v = 0, p_f = 0, p_p = 0, p_o = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // A new word is presented when rx_valid rises or the held word/flags change while valid.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && (!p_v || rx_data !== p_data || frame_err !== p_f ||
                                   parity_err !== p_p || overrun_err !== p_o)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h with no frame outstanding", rx_data);
            end else begin
                m_e = sb.pop_front();
                chk("rx_data", rx_data, m_e.data);
                chk("frame_err", frame_err, m_e.ferr);
                chk("parity_err", parity_err, m_e.perr);
                chk("overrun_err", overrun_err, m_e.ovr);
                chk("latency_cycle", cyc, m_e.t);
            end
        end
        p_v    = rx_valid;
        p_data = rx_data;
        p_f    = frame_err;
        p_p    = parity_err;
        p_o    = overrun_err;
    end

    task automatic line(input logic v, input int n);
        serial_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [8:0] d, input int stop_low, input bit bad_par);
        exp_t e;
        e.data = d[DW-1:0];
        e.ferr = stop_low > 0;
        e.perr = (P == 1) && bad_par;
        ovr_m  = ovr_m | held;
        e.ovr  = ovr_m;
        held   = 1;
        e.t    = cyc + 1 + L;
        sb.push_back(e);
        line(1'b0, C);
        for (int i = 0; i < DW; i++) line(d[i], C);
        if (P == 1) line((^e.data) ^ (ODD != 0) ^ bad_par, C);
        if (stop_low > 0) line(1'b0, stop_low * C);
        line(1'b1, C);
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        held   = 0;
        ovr_m  = 0;
        chk("ack_valid", rx_valid, 0);
        chk("ack_frame_err", frame_err, 0);
        chk("ack_parity_err", parity_err, 0);
        chk("ack_overrun_err", overrun_err, 0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_data"}, rx_data, 0);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_flags"}, {frame_err, parity_err, overrun_err}, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_cleared("reset");
        send(9'h0A5, 0, 0);
        chk("post_frame_busy", busy, 0);
        ack();
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy", busy, 1);
        repeat (6) @(negedge clk);
        chk("glitch_idle", busy, 0);
        chk("glitch_valid", rx_valid, 0);
        send(9'h03C, 20, 0);
        chk("break_exit_busy", busy, 0);
        ack();
        send(9'h081, 0, 0);
        ack();
        send(9'h011, 0, 0);
        send(9'h022, 0, 0);
        ack();
        send(9'h055, 0, 0);
        ack();
        send(9'h055, 0, 1);
        ack();
        for (int n = 0; n < 10; n++) begin
            send(9'($urandom), $urandom_range(0, 3) == 0 ? 1 : 0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2 * C)) @(negedge clk);
            ack();
        end
        send(9'h05A, 0, 0);
        line(1'b0, C);
        for (int i = 0; i < 4; i++) line(1'($urandom_range(0, 1)), C);
        line(1'b1, H);
        chk("pre_reset_busy", busy, 1);
        rst       = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        held  = 0;
        ovr_m = 0;
        check_cleared("mid_reset");
        repeat (2 * C) @(negedge clk);
        send(9'h0F0, 0, 0);
        ack();
        repeat (10) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
